// File: rtl/data_mem_hs.sv
// Byte-addressed big-endian data memory for the MEM stage.
// Request/ready handshake with optional wait states.
module data_mem_hs #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] out32,
  output logic        ready,
  output logic        busy,
  output logic        misaligned
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [ADDR_BITS-1:0] addr_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  addr_t       addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] out32_q;

  logic [7:0]  mem_q [DEPTH];

  addr_t       a_acc;
  logic [31:0] wd_acc;
  logic [1:0]  sz_acc;
  logic        se_acc;
  logic        rd_acc;
  logic        wr_acc;

  logic        enter_resp;
  logic        err_acc;
  logic        do_wr;
  logic        do_rd;
  addr_t       a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] load_val;
  logic        unused_addr;

  assign unused_addr = ^address[31:ADDR_BITS];

  // Array is stored XOR'ed with the power-up image so that an
  // all-zero power-up state reads back as 00..00 FF FF FF FF 00..
  function automatic logic [7:0] init_pat(input addr_t a);
    return ({a[ADDR_BITS-1:2], 2'b00} == addr_t'(4)) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic bad_align(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (sz)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the access happens on the acceptance edge,
  // so operands come straight from the inputs instead of the latches.
  always_comb begin
    a_acc  = addr_q;
    wd_acc = wdata_q;
    sz_acc = size_q;
    se_acc = sext_q;
    rd_acc = rd_q;
    wr_acc = wr_q;
    if (state_q == IDLE) begin
      a_acc  = address[ADDR_BITS-1:0];
      wd_acc = writeData;
      sz_acc = size;
      se_acc = sign_ext;
      rd_acc = memread;
      wr_acc = memwrite;
    end
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign err_acc    = bad_align(sz_acc, a_acc[1:0]);
  assign do_wr      = enter_resp && !rst && wr_acc && !err_acc;
  assign do_rd      = enter_resp && !wr_acc && rd_acc && !err_acc;

  assign a1 = a_acc + addr_t'(1);
  assign a2 = a_acc + addr_t'(2);
  assign a3 = a_acc + addr_t'(3);

  assign b0 = mem_q[a_acc] ^ init_pat(a_acc);
  assign b1 = mem_q[a1] ^ init_pat(a1);
  assign b2 = mem_q[a2] ^ init_pat(a2);
  assign b3 = mem_q[a3] ^ init_pat(a3);

  always_comb begin
    load_val = {b0, b1, b2, b3};
    unique case (sz_acc)
      2'b00:   load_val = {{24{se_acc & b0[7]}}, b0};
      2'b01:   load_val = {{16{se_acc & b0[7]}}, b0, b1};
      default: load_val = {b0, b1, b2, b3};
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      unique case (sz_acc)
        2'b00: begin
          mem_q[a_acc] <= wd_acc[7:0] ^ init_pat(a_acc);
        end
        2'b01: begin
          mem_q[a_acc] <= wd_acc[15:8] ^ init_pat(a_acc);
          mem_q[a1]    <= wd_acc[7:0] ^ init_pat(a1);
        end
        default: begin
          mem_q[a_acc] <= wd_acc[31:24] ^ init_pat(a_acc);
          mem_q[a1]    <= wd_acc[23:16] ^ init_pat(a1);
          mem_q[a2]    <= wd_acc[15:8] ^ init_pat(a2);
          mem_q[a3]    <= wd_acc[7:0] ^ init_pat(a3);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      out32_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        addr_q  <= address[ADDR_BITS-1:0];
        wdata_q <= writeData;
        size_q  <= size;
        sext_q  <= sign_ext;
        rd_q    <= memread;
        wr_q    <= memwrite;
      end
      if (do_rd) begin
        out32_q <= load_val;
      end
    end
  end

  assign out32      = out32_q;
  assign ready      = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign misaligned = (state_q == RESP) && (rd_q || wr_q) &&
                      bad_align(size_q, addr_q[1:0]);

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: two instances (0 and 3 wait states) checked
// against a byte-array reference model with directed and random ops.
module tb_data_mem_hs;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic        memread, memwrite, sign_ext;
  logic [1:0]  size;
  logic [31:0] address, writeData;

  logic [31:0] o32 [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        mis [2];

  int          checks = 0;
  int          errors = 0;
  int          wc [2] = '{0, 3};
  logic [7:0]  mem_m [256];
  logic [31:0] exp_out [2];

  data_mem_hs #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0),
    .memread(memread), .memwrite(memwrite),
    .size(size), .sign_ext(sign_ext),
    .address(address), .writeData(writeData),
    .out32(o32[0]), .ready(rdy[0]),
    .busy(bsy[0]), .misaligned(mis[0])
  );

  data_mem_hs #(.ADDR_BITS(8), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .req(req1),
    .memread(memread), .memwrite(memwrite),
    .size(size), .sign_ext(sign_ext),
    .address(address), .writeData(writeData),
    .out32(o32[1]), .ready(rdy[1]),
    .busy(bsy[1]), .misaligned(mis[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: bytes taken most-significant first, n = 1/2/4.
  task automatic model(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic m, output logic ld,
                       output logic [31:0] v);
    int base, n;
    base = int'(a % 256);
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    m    = (rd || wr) && (sz == 2'd3 || (base % n) != 0);
    ld   = 1'b0;
    v    = 32'd0;
    if (!m && wr) begin
      for (int i = 0; i < n; i++)
        mem_m[(base + i) % 256] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
    end else if (!m && rd) begin
      ld = 1'b1;
      for (int i = 0; i < n; i++)
        v = (v << 8) | 32'(mem_m[(base + i) % 256]);
      if (se && n < 4 && v[8 * n - 1])
        v = v | (32'hFFFF_FFFF << (8 * n));
    end
  endtask

  task automatic scramble();
    memread   = 1'($urandom);
    memwrite  = 1'($urandom);
    size      = 2'($urandom);
    sign_ext  = 1'($urandom);
    address   = $urandom;
    writeData = $urandom;
  endtask

  task automatic op(input logic u0, input logic u1,
                    input logic rd, input logic wr,
                    input logic [1:0] sz, input logic se,
                    input logic [31:0] a, input logic [31:0] d);
    logic m, ld, er;
    logic [31:0] v;
    logic u [2];
    u[0] = u0;
    u[1] = u1;
    model(rd, wr, sz, se, a, d, m, ld, v);
    for (int i = 0; i < 2; i++)
      if (u[i] && ld) exp_out[i] = v;
    memread   = rd;
    memwrite  = wr;
    size      = sz;
    sign_ext  = se;
    address   = a;
    writeData = d;
    req0      = u0;
    req1      = u1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    scramble();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (u[i]) begin
          er = (k == wc[i] + 1);
          chk($sformatf("ready%0d k%0d", i, k), 32'(rdy[i]), 32'(er));
          chk($sformatf("busy%0d k%0d", i, k), 32'(bsy[i]),
              32'(k <= wc[i] + 1));
          chk($sformatf("mis%0d k%0d", i, k), 32'(mis[i]),
              32'(er && m));
          if (er)
            chk($sformatf("out%0d a=%08h", i, a), o32[i], exp_out[i]);
        end else begin
          chk($sformatf("idle ready%0d", i), 32'(rdy[i]), 32'd0);
        end
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s out%0d", tag, i), o32[i], 32'd0);
      chk($sformatf("%s ready%0d", tag, i), 32'(rdy[i]), 32'd0);
      chk($sformatf("%s busy%0d", tag, i), 32'(bsy[i]), 32'd0);
      chk($sformatf("%s mis%0d", tag, i), 32'(mis[i]), 32'd0);
    end
  endtask

  initial begin
    logic m, ld;
    logic [31:0] v;
    for (int i = 0; i < 256; i++)
      mem_m[i] = (i >= 4 && i <= 7) ? 8'hFF : 8'h00;
    exp_out = '{32'd0, 32'd0};
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    scramble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;

    op(1, 1, 1, 0, 2'd2, 0, 32'd4, 32'd0);
    chk("lw 4", o32[0], 32'hFFFF_FFFF);
    op(1, 1, 1, 0, 2'd2, 0, 32'd0, 32'd0);
    chk("lw 0", o32[1], 32'h0000_0000);

    op(1, 1, 0, 1, 2'd2, 0, 32'd252, 32'h1122_3344);
    chk("sw keeps out", o32[0], 32'h0000_0000);
    op(1, 1, 1, 0, 2'd0, 0, 32'd252, 32'd0);
    chk("lbu 252", o32[0], 32'h0000_0011);
    op(1, 1, 1, 0, 2'd0, 0, 32'd255, 32'd0);
    chk("lbu 255", o32[1], 32'h0000_0044);
    op(1, 1, 1, 0, 2'd1, 1, 32'd254, 32'd0);
    chk("lh 254", o32[0], 32'h0000_3344);
    op(1, 1, 0, 1, 2'd0, 0, 32'd253, 32'h0000_00F0);
    op(1, 1, 1, 0, 2'd2, 0, 32'd252, 32'd0);
    chk("lw 252", o32[1], 32'h11F0_3344);
    op(1, 1, 1, 0, 2'd0, 1, 32'd253, 32'd0);
    chk("lb 253", o32[0], 32'hFFFF_FFF0);

    op(1, 1, 0, 1, 2'd2, 0, 32'd6, 32'hDEAD_BEEF);
    op(1, 1, 1, 0, 2'd2, 0, 32'd4, 32'd0);
    chk("lw 4 after bad sw", o32[1], 32'hFFFF_FFFF);
    op(1, 1, 1, 0, 2'd3, 0, 32'd8, 32'd0);
    op(1, 1, 1, 1, 2'd1, 0, 32'd3, 32'h5555_5555);
    op(1, 1, 0, 0, 2'd3, 0, 32'd1, 32'd0);

    op(1, 1, 0, 1, 2'd2, 0, 32'h100, 32'hA5A5_0F0F);
    op(1, 1, 1, 0, 2'd2, 0, 32'd0, 32'd0);
    chk("alias 0x100", o32[0], 32'hA5A5_0F0F);

    // Wait-state instance alone, with req pulses while busy.
    model(1, 0, 2'd2, 0, 32'd4, 32'd0, m, ld, v);
    exp_out[1] = v;
    memread  = 1'b1;
    memwrite = 1'b0;
    size     = 2'd2;
    sign_ext = 1'b0;
    address  = 32'd4;
    req1     = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("pulse ready1 k%0d", k), 32'(rdy[1]), 32'(k == 4));
      chk($sformatf("pulse busy1 k%0d", k), 32'(bsy[1]), 32'(k <= 4));
      chk($sformatf("pulse ready0 k%0d", k), 32'(rdy[0]), 32'd0);
      if (k == 4) chk("pulse out1", o32[1], 32'hFFFF_FFFF);
      req1 = (k == 2 || k == 3);
    end

    // Reset during the wait of a store aborts it.
    memread   = 1'b0;
    memwrite  = 1'b1;
    size      = 2'd2;
    address   = 32'd8;
    writeData = 32'hCAFE_BABE;
    req1      = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    chk("abort busy1", 32'(bsy[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_out = '{32'd0, 32'd0};
    chk_reset_outs("abort");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("abort ready1 k%0d", k), 32'(rdy[1]), 32'd0);
    end
    op(1, 1, 1, 0, 2'd2, 0, 32'd8, 32'd0);
    chk("abort lw 8", o32[1], 32'h0000_0000);

    for (int t = 0; t < 60; t++) begin
      op(1, 1, 1'($urandom), 1'($urandom), 2'($urandom),
         1'($urandom), $urandom_range(0, 600), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
